// File: rtl/fwd_pipe.sv
// fwd_pipe: parametrised write-back pipeline tracker with forwarding.
// Carries results through STAGES registers, merges late load data,
// forwards youngest-first on two lookup ports, raises load-use stall.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   in_valid/in_wreg   new result valid / writes a register
//   in_wd/in_wdata     destination / data of new result
//   in_rdy             1: data final, 0: load, data comes via ld_data
//   ld_data            late data merged on entry to LOAD_STAGE
//   stall, flush       freeze all / kill in-flight (flush wins)
//   raddr1/2           forwarding lookup addresses
//   fwd1/2_hit/_data   lookup result (data 0 on miss or not ready)
//   fwd_stall          a lookup hit a not-ready entry
//   wb_we/waddr/wdata  register-file write port (last stage)
//   occupancy          registered count of valid stages
module fwd_pipe #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int STAGES     = 3,
   parameter int LOAD_STAGE = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic                         in_wreg,
   input  logic [ADDR_W-1:0]            in_wd,
   input  logic [DATA_W-1:0]            in_wdata,
   input  logic                         in_rdy,
   input  logic [DATA_W-1:0]            ld_data,
   input  logic                         stall,
   input  logic                         flush,
   input  logic [ADDR_W-1:0]            raddr1,
   input  logic [ADDR_W-1:0]            raddr2,
   output logic                         fwd1_hit,
   output logic                         fwd2_hit,
   output logic [DATA_W-1:0]            fwd1_data,
   output logic [DATA_W-1:0]            fwd2_data,
   output logic                         fwd_stall,
   output logic                         wb_we,
   output logic [ADDR_W-1:0]            wb_waddr,
   output logic [DATA_W-1:0]            wb_wdata,
   output logic [$clog2(STAGES+1)-1:0]  occupancy
);

   localparam int L  = STAGES - 1;
   localparam int OW = $clog2(STAGES + 1);

   logic [STAGES-1:0] v;
   logic [STAGES-1:0] wreg;
   logic [STAGES-1:0] rdy;
   logic [ADDR_W-1:0] wd   [STAGES];
   logic [DATA_W-1:0] data [STAGES];
   logic [OW-1:0]     occ;
   logic [STAGES-1:0] v_adv;

   logic              hit1, hit2;
   logic              nr1, nr2;
   logic [DATA_W-1:0] fd1, fd2;

   assign v_adv = {v[STAGES-2:0], in_valid};

   function automatic logic [OW-1:0] popcnt(
      input logic [STAGES-1:0] b
   );
      logic [OW-1:0] c;
      c = '0;
      for (int i = 0; i < STAGES; i++)
         c = c + OW'(b[i]);
      return c;
   endfunction

   // Flush clears every stage, including the last one, which still
   // retires combinationally in the flush cycle before it is cleared.
   // Bubbles carry zero fields so idle write-back outputs read 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v    <= '0;
         wreg <= '0;
         rdy  <= '0;
         occ  <= '0;
         for (int s = 0; s < STAGES; s++) begin
            wd[s]   <= '0;
            data[s] <= '0;
         end
      end else if (flush) begin
         v    <= '0;
         wreg <= '0;
         rdy  <= '0;
         occ  <= '0;
         for (int s = 0; s < STAGES; s++) begin
            wd[s]   <= '0;
            data[s] <= '0;
         end
      end else if (!stall) begin
         v       <= v_adv;
         occ     <= popcnt(v_adv);
         wreg[0] <= in_valid & in_wreg;
         rdy[0]  <= in_valid & in_rdy;
         wd[0]   <= in_valid ? in_wd : '0;
         data[0] <= in_valid ? in_wdata : '0;
         for (int s = 1; s < STAGES; s++) begin
            wreg[s] <= wreg[s-1];
            wd[s]   <= wd[s-1];
            if (s == LOAD_STAGE && v[s-1] && !rdy[s-1]) begin
               data[s] <= ld_data;
               rdy[s]  <= 1'b1;
            end else begin
               data[s] <= data[s-1];
               rdy[s]  <= rdy[s-1];
            end
         end
      end
   end

   // Scan oldest to youngest so the youngest match is written last
   // and wins, whether it is ready or not.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      nr1  = 1'b0;
      nr2  = 1'b0;
      fd1  = '0;
      fd2  = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
         if (v[s] && wreg[s] && wd[s] == raddr1 && raddr1 != '0) begin
            hit1 = 1'b1;
            nr1  = !rdy[s];
            fd1  = rdy[s] ? data[s] : '0;
         end
         if (v[s] && wreg[s] && wd[s] == raddr2 && raddr2 != '0) begin
            hit2 = 1'b1;
            nr2  = !rdy[s];
            fd2  = rdy[s] ? data[s] : '0;
         end
      end
   end

   assign fwd1_hit  = hit1;
   assign fwd2_hit  = hit2;
   assign fwd1_data = fd1;
   assign fwd2_data = fd2;
   assign fwd_stall = nr1 | nr2;

   // Flush overrides stall, so the last stage retires on a flush.
   assign wb_we     = v[L] & wreg[L] & rdy[L] & ~(stall & ~flush);
   assign wb_waddr  = wd[L];
   assign wb_wdata  = data[L];
   assign occupancy = occ;

endmodule

// File: tb/tb_fwd_pipe.sv
// tb_fwd_pipe: directed table vectors, reset sequences and a
// randomized run checked against a transaction-queue model.
module tb_fwd_pipe;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int ST = 3;
   localparam int LS = 1;
   localparam int OW = $clog2(ST + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_wreg, in_rdy;
   logic [AW-1:0] in_wd;
   logic [DW-1:0] in_wdata, ld_data;
   logic          stall, flush;
   logic [AW-1:0] raddr1, raddr2;
   logic          fwd1_hit, fwd2_hit, fwd_stall, wb_we;
   logic [DW-1:0] fwd1_data, fwd2_data, wb_wdata;
   logic [AW-1:0] wb_waddr;
   logic [OW-1:0] occupancy;

   fwd_pipe #(
      .DATA_W(DW), .ADDR_W(AW), .STAGES(ST), .LOAD_STAGE(LS)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_wreg(in_wreg), .in_wd(in_wd),
      .in_wdata(in_wdata), .in_rdy(in_rdy), .ld_data(ld_data),
      .stall(stall), .flush(flush),
      .raddr1(raddr1), .raddr2(raddr2),
      .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
      .fwd_stall(fwd_stall), .wb_we(wb_we),
      .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Directed vectors: inputs for one cycle plus the outputs expected
   // during that cycle (before the edge that consumes the inputs).
   typedef struct {
      logic [31:0] iv, wr, wd, wdat, rdy, ld, st, fl, r1, r2;
      logic [31:0] h1, d1, h2, d2, fs, we, wa, wv, occ;
   } vec_t;
   vec_t tbl[$];

   // Reference model: in-flight transactions, youngest first, each
   // tagged with how many advancing edges it has seen.
   typedef struct {
      logic          wreg;
      logic [AW-1:0] wd;
      logic [DW-1:0] data;
      logic          rdy;
      int            pos;
   } ent_t;
   ent_t q[$];

   function automatic void m_look(input logic [AW-1:0] a,
      output logic h, output logic [DW-1:0] d, output logic nr);
      h = 1'b0; d = '0; nr = 1'b0;
      if (a != 0)
         foreach (q[i])
            if (!h && q[i].wreg && q[i].wd == a) begin
               h  = 1'b1;
               d  = q[i].rdy ? q[i].data : '0;
               nr = !q[i].rdy;
            end
   endfunction

   task automatic m_check(input string tag);
      logic h1, h2, n1, n2, we;
      logic [DW-1:0] d1, d2;
      m_look(raddr1, h1, d1, n1);
      m_look(raddr2, h2, d2, n2);
      we = 1'b0;
      if (q.size() > 0)
         we = q[$].pos == ST - 1 && q[$].wreg && q[$].rdy &&
              !(stall && !flush);
      chk({tag, "_h1"}, 32'(fwd1_hit), 32'(h1));
      chk({tag, "_d1"}, fwd1_data, d1);
      chk({tag, "_h2"}, 32'(fwd2_hit), 32'(h2));
      chk({tag, "_d2"}, fwd2_data, d2);
      chk({tag, "_fs"}, 32'(fwd_stall), 32'(n1 | n2));
      chk({tag, "_we"}, 32'(wb_we), 32'(we));
      chk({tag, "_occ"}, 32'(occupancy), 32'(q.size()));
      if (we) begin
         chk({tag, "_wa"}, 32'(wb_waddr), 32'(q[$].wd));
         chk({tag, "_wv"}, wb_wdata, q[$].data);
      end
   endtask

   task automatic m_step();
      ent_t e;
      if (flush) q.delete();
      else if (!stall) begin
         foreach (q[i]) begin
            q[i].pos++;
            if (q[i].pos == LS && !q[i].rdy) begin
               q[i].data = ld_data;
               q[i].rdy  = 1'b1;
            end
         end
         if (q.size() > 0 && q[$].pos == ST) void'(q.pop_back());
         if (in_valid) begin
            e = '{in_wreg, in_wd, in_wdata, in_rdy, 0};
            q.push_front(e);
         end
      end
   endtask

   task automatic drive(input vec_t v);
      in_valid = v.iv[0];
      in_wreg  = v.wr[0];
      in_wd    = v.wd[AW-1:0];
      in_wdata = v.wdat;
      in_rdy   = v.rdy[0];
      ld_data  = v.ld;
      stall    = v.st[0];
      flush    = v.fl[0];
      raddr1   = v.r1[AW-1:0];
      raddr2   = v.r2[AW-1:0];
   endtask

   task automatic idle();
      in_valid = 0; in_wreg = 0; in_wd = 0; in_wdata = 0;
      in_rdy = 1; ld_data = 0; stall = 0; flush = 0;
   endtask

   initial begin
      // single ready write to r5
      tbl.push_back('{1,1,5,'h1234,1,0,0,0,5,0, 0,0,0,0,0,0,0,0,0});
      tbl.push_back('{0,0,0,0,1,0,0,0,5,0, 1,'h1234,0,0,0,0,0,0,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,5,0, 1,'h1234,0,0,0,0,0,0,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,5,0, 1,'h1234,0,0,0,1,5,'h1234,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,5,0, 0,0,0,0,0,0,0,0,0});
      // back-to-back r7
      tbl.push_back('{1,1,7,'hA,1,0,0,0,0,7, 0,0,0,0,0,0,0,0,0});
      tbl.push_back('{1,1,7,'hB,1,0,0,0,0,7, 0,0,1,'hA,0,0,0,0,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,0,7, 0,0,1,'hB,0,0,0,0,2});
      tbl.push_back('{0,0,0,0,1,0,0,0,0,7, 0,0,1,'hB,0,1,7,'hA,2});
      tbl.push_back('{0,0,0,0,1,0,0,0,0,7, 0,0,1,'hB,0,1,7,'hB,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,0,7, 0,0,0,0,0,0,0,0,0});
      // load r3, late data 0xCAFE
      tbl.push_back('{1,1,3,'hDEAD,0,0,0,0,3,0, 0,0,0,0,0,0,0,0,0});
      tbl.push_back('{0,0,0,0,1,'hCAFE,0,0,3,0, 1,0,0,0,1,0,0,0,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,3,0, 1,'hCAFE,0,0,0,0,0,0,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,3,0, 1,'hCAFE,0,0,0,1,3,'hCAFE,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,3,0, 0,0,0,0,0,0,0,0,0});
      // two stall cycles with entry in stage 1, input ignored
      tbl.push_back('{1,1,9,'h99,1,0,0,0,9,0, 0,0,0,0,0,0,0,0,0});
      tbl.push_back('{0,0,0,0,1,0,0,0,9,0, 1,'h99,0,0,0,0,0,0,1});
      tbl.push_back('{1,1,20,'h20,1,0,1,0,9,0, 1,'h99,0,0,0,0,0,0,1});
      tbl.push_back('{1,1,20,'h20,1,0,1,0,9,0, 1,'h99,0,0,0,0,0,0,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,9,0, 1,'h99,0,0,0,0,0,0,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,9,0, 1,'h99,0,0,0,1,9,'h99,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,9,0, 0,0,0,0,0,0,0,0,0});
      // full pipe, flush with stall
      tbl.push_back('{1,1,10,10,1,0,0,0,12,0, 0,0,0,0,0,0,0,0,0});
      tbl.push_back('{1,1,11,11,1,0,0,0,12,0, 0,0,0,0,0,0,0,0,1});
      tbl.push_back('{1,1,12,12,1,0,0,0,12,0, 0,0,0,0,0,0,0,0,2});
      tbl.push_back('{1,1,13,13,1,0,1,1,12,0, 1,12,0,0,0,1,10,10,3});
      tbl.push_back('{0,0,0,0,1,0,0,0,12,0, 0,0,0,0,0,0,0,0,0});
      tbl.push_back('{0,0,0,0,1,0,0,0,13,0, 0,0,0,0,0,0,0,0,0});
      // write to r0 never forwards
      tbl.push_back('{1,1,0,'h55,1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0});
      tbl.push_back('{0,0,0,0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,0,0, 0,0,0,0,0,1,0,'h55,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0});
      // younger not-ready r4 masks older ready r4
      tbl.push_back('{1,1,4,'h44,1,0,0,0,4,0, 0,0,0,0,0,0,0,0,0});
      tbl.push_back('{1,1,4,'hEE,0,0,0,0,4,0, 1,'h44,0,0,0,0,0,0,1});
      tbl.push_back('{0,0,0,0,1,'h77,0,0,4,0, 1,0,0,0,1,0,0,0,2});
      tbl.push_back('{0,0,0,0,1,0,0,0,4,0, 1,'h77,0,0,0,1,4,'h44,2});
      tbl.push_back('{0,0,0,0,1,0,0,0,4,0, 1,'h77,0,0,0,1,4,'h77,1});
      tbl.push_back('{0,0,0,0,1,0,0,0,4,0, 0,0,0,0,0,0,0,0,0});

      rst = 1'b1;
      idle();
      raddr1 = 5;
      raddr2 = 7;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_occ", 32'(occupancy), 0);
      chk("rst_we", 32'(wb_we), 0);
      chk("rst_h1", 32'(fwd1_hit), 0);
      chk("rst_fs", 32'(fwd_stall), 0);
      chk("rst_wa", 32'(wb_waddr), 0);
      chk("rst_wv", wb_wdata, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_occ", 32'(occupancy), 0);
      chk("post_rst_we", 32'(wb_we), 0);
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk);
         chk($sformatf("row%0d_h1", i), 32'(fwd1_hit), tbl[i].h1);
         chk($sformatf("row%0d_d1", i), fwd1_data, tbl[i].d1);
         chk($sformatf("row%0d_h2", i), 32'(fwd2_hit), tbl[i].h2);
         chk($sformatf("row%0d_d2", i), fwd2_data, tbl[i].d2);
         chk($sformatf("row%0d_fs", i), 32'(fwd_stall), tbl[i].fs);
         chk($sformatf("row%0d_we", i), 32'(wb_we), tbl[i].we);
         chk($sformatf("row%0d_occ", i), 32'(occupancy), tbl[i].occ);
         if (tbl[i].we[0]) begin
            chk($sformatf("row%0d_wa", i), 32'(wb_waddr), tbl[i].wa);
            chk($sformatf("row%0d_wv", i), wb_wdata, tbl[i].wv);
         end
         @(posedge clk);
         #1;
      end

      // reset in the middle of operation discards in-flight entries
      idle();
      raddr1 = 1;
      in_valid = 1; in_wreg = 1; in_wd = 1; in_wdata = 'h111;
      @(posedge clk);
      #1 in_wd = 2; in_wdata = 'h222;
      @(posedge clk);
      #1 idle();
      rst = 1'b1;
      #1;
      chk("mid_rst_occ", 32'(occupancy), 0);
      chk("mid_rst_h1", 32'(fwd1_hit), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("mid_rst_we%0d", c), 32'(wb_we), 0);
         chk($sformatf("mid_rst_oc%0d", c), 32'(occupancy), 0);
      end
      @(posedge clk);
      #1;

      // randomized run against the transaction model
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         in_wreg  = ($urandom_range(0, 9) < 8);
         in_wd    = AW'($urandom_range(0, 7));
         in_wdata = $urandom;
         in_rdy   = ($urandom_range(0, 3) != 0);
         ld_data  = $urandom;
         stall    = ($urandom_range(0, 99) < 15);
         flush    = ($urandom_range(0, 99) < 3);
         raddr1   = AW'($urandom_range(0, 7));
         raddr2   = AW'($urandom_range(0, 7));
         @(negedge clk);
         m_check($sformatf("rnd%0d", c));
         @(posedge clk);
         m_step();
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fwd_pipe.md
# fwd_pipe

Parametrised write-back pipeline tracker for the flow CPU. It carries register-write results (destination, enable, data) from the execute output through `STAGES` registered stages to the register file. It generalises the fixed EX/MEM/WB chain with stall, flush and late (load) data injection. It also offers two forwarding lookup ports with youngest-first priority and raises a load-use stall request.

## Interface

Parameters:

- `DATA_W`, 32, data width
- `ADDR_W`, 5, register address width
- `STAGES`, 3, number of stage registers (2..8); stage 0 youngest, stage `STAGES-1` retires
- `LOAD_STAGE`, 1, stage (1..`STAGES-1`) at which late data is merged

Ports:

- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `in_valid` in 1: a result enters stage 0 at this edge
- `in_wreg` in 1: result writes a register
- `in_wd` in `ADDR_W`: destination register
- `in_wdata` in `DATA_W`: result data
- `in_rdy` in 1: 1 means data is final; 0 means load, and data arrives later
- `ld_data` in `DATA_W`: late data for the entry entering `LOAD_STAGE`
- `stall` in 1: freeze all stages
- `flush` in 1: kill stages 0..`STAGES-2`
- `raddr1`, `raddr2` in `ADDR_W`: forwarding lookup addresses
- `fwd1_hit`, `fwd2_hit` out 1: lookup matched an in-flight entry
- `fwd1_data`, `fwd2_data` out `DATA_W`: forwarded data; 0 when there is no hit
- `fwd_stall` out 1: a lookup matched a not-ready entry
- `wb_we` out 1: register-file write enable
- `wb_waddr` out `ADDR_W`: register-file write address
- `wb_wdata` out `DATA_W`: register-file write data
- `occupancy` out `$clog2(STAGES+1)`: number of valid stages

## Operation

- Each stage s holds `v[s]`, `wreg[s]`, `wd[s]`, `data[s]`, `rdy[s]`.
- Advance (`stall`=0, `flush`=0):
  - Stage 0 loads `in_*` with `v[0]`=`in_valid`.
  - Stage s loads stage s-1 contents.
- Load merge: when an entry with `rdy`=0 moves into `LOAD_STAGE`, its data becomes `ld_data` and its `rdy` becomes 1. Entries with `rdy`=1 pass their data unchanged.
- Retire:
  - `wb_we` = `v[STAGES-1]` & `wreg[STAGES-1]` & `rdy[STAGES-1]` & !`stall`.
  - `wb_waddr` and `wb_wdata` come directly from the last stage.
  - An entry retires exactly once.
- Stall:
  - All stage registers hold; `in_*` is ignored.
  - `wb_we` is forced to 0 during stall, so the write happens on the advancing cycle.
- Flush:
  - At the next edge `v[0..STAGES-2]` all clear and stage 0 takes a bubble.
  - The last stage still retires normally this cycle and then becomes invalid.
  - Flush overrides stall; `in_valid` is ignored that cycle.
- Forwarding (combinational, per port k):
  - An entry matches when `v[s]` & `wreg[s]` & (`wd[s]`==`raddrk`) & (`raddrk`!=0).
  - The lowest-index (youngest) matching stage wins.
  - `fwdk_hit`=1 and `fwdk_data`=`data[s]` when the winner has `rdy`=1.
  - If the winner has `rdy`=0, `fwdk_hit`=1, `fwdk_data`=0 and `fwd_stall`=1.
  - An older ready match never masks a younger not-ready one.
  - Register 0 never hits.
- `occupancy` is the registered count of `v` bits, updated on every edge in the same cycle as `v`.

## Timing

- Asynchronous reset clears all `v`, `wreg`, `rdy`, `wd` and `data` to 0. All outputs read 0 during and after reset until the first valid entry.
- Latency from `in_valid` to `wb_we` is `STAGES` non-stalled cycles.
- An entry becomes visible on the forwarding ports one edge after entry.
- Each stall cycle adds exactly one cycle of latency.
- `fwd_stall` depends combinationally on `raddr*` and state. It must not depend on `stall`, so no combinational loop is created.
- Back-to-back writes to the same register: forwarding returns the younger value, and the register file receives both writes in order.
- Reset mid-operation discards all in-flight entries with no write.

## Test plan

- Reset, then `in_valid`=1, `in_wd`=5, `in_wdata`=0x1234, `in_rdy`=1 → `fwd1_hit`=1 with 0x1234 for `raddr1`=5 at cycles 1..3; `wb_we`=1, `wb_waddr`=5 at cycle 3 only.
- Writes r7=0xA then r7=0xB on consecutive cycles, `raddr2`=7 → `fwd2_data`=0xB once both are in flight; retires 0xA then 0xB.
- Load r3 (`in_rdy`=0), `raddr1`=3 → `fwd_stall`=1 while in stage 0; `ld_data`=0xCAFE on entry to stage 1 → hit 0xCAFE, `fwd_stall`=0, retire writes 0xCAFE.
- Entry in stage 1, assert `stall` for 2 cycles → state frozen, `wb_we`=0, retire delayed by exactly 2 cycles, single write.
- Entries in stages 0, 1, 2 plus `flush` (with `stall`=1) → stage-2 entry retires (`wb_we`=0 because stalled? no: flush overrides, so `wb_we`=1); `occupancy`=0 next cycle; no further writes.
- `raddr1`=0 with a valid write to r0 in flight → `fwd1_hit`=0, `fwd1_data`=0.
